// File: rtl/alu_fifo_dispatcher.sv
// Single-issue ALU command dispatcher: pops {data_1, data_0, id, op} from FIFO_IN,
// executes the 2-bit op and pushes {id, result} to FIFO_OUT under backpressure.
module alu_fifo_dispatcher #(
  parameter int unsigned OPERATION_SIZE = 2,
  parameter int unsigned ID_SIZE        = 8,
  parameter int unsigned DATA_SIZE      = 16,
  parameter int unsigned RESULT_SIZE    = DATA_SIZE + 1,
  parameter int unsigned FIFO_IN_WIDTH  = 2*DATA_SIZE + ID_SIZE + OPERATION_SIZE,
  parameter int unsigned FIFO_OUT_WIDTH = ID_SIZE + RESULT_SIZE,
  parameter int unsigned COUNT_SIZE     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [FIFO_IN_WIDTH-1:0]  fifo_in_data,
  input  logic                      fifo_in_empty,
  output logic                      fifo_in_r_en,
  input  logic                      fifo_out_full,
  output logic                      fifo_out_w_en,
  output logic [FIFO_OUT_WIDTH-1:0] fifo_out_data,
  output logic                      busy,
  output logic [COUNT_SIZE-1:0]     op_count
);

  localparam int unsigned ID_LSB = OPERATION_SIZE;
  localparam int unsigned A_LSB  = OPERATION_SIZE + ID_SIZE;
  localparam int unsigned B_LSB  = OPERATION_SIZE + ID_SIZE + DATA_SIZE;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_POP  = 3'd1,
    S_CAPT = 3'd2,
    S_EXEC = 3'd3,
    S_PUSH = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } alu_op_t;

  state_t                    state_q, state_d;
  logic [OPERATION_SIZE-1:0] op_q, op_d;
  logic [ID_SIZE-1:0]        id_q, id_d;
  logic [DATA_SIZE-1:0]      a_q, a_d;
  logic [DATA_SIZE-1:0]      b_q, b_d;
  logic [FIFO_OUT_WIDTH-1:0] out_q, out_d;
  logic [COUNT_SIZE-1:0]     op_count_q, op_count_d;

  logic [RESULT_SIZE-1:0]    a_ext, b_ext, result;

  // Operands are zero-extended so bit DATA_SIZE carries the carry/borrow.
  always_comb begin
    a_ext  = RESULT_SIZE'(a_q);
    b_ext  = RESULT_SIZE'(b_q);
    result = '0;
    case (alu_op_t'(op_q))
      OP_ADD:  result = a_ext + b_ext;
      OP_SUB:  result = a_ext - b_ext;
      OP_AND:  result = a_ext & b_ext;
      OP_XOR:  result = a_ext ^ b_ext;
      default: result = '0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    id_d          = id_q;
    a_d           = a_q;
    b_d           = b_q;
    out_d         = out_q;
    op_count_d    = op_count_q;
    fifo_in_r_en  = 1'b0;
    fifo_out_w_en = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_in_empty) begin
          state_d = S_POP;
        end
      end
      S_POP: begin
        fifo_in_r_en = 1'b1;
        state_d      = S_CAPT;
      end
      S_CAPT: begin
        op_d    = fifo_in_data[OPERATION_SIZE-1:0];
        id_d    = fifo_in_data[ID_LSB +: ID_SIZE];
        a_d     = fifo_in_data[A_LSB +: DATA_SIZE];
        b_d     = fifo_in_data[B_LSB +: DATA_SIZE];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        out_d   = {id_q, result};
        state_d = S_PUSH;
      end
      S_PUSH: begin
        // Output word stays registered and untouched while FIFO_OUT is full.
        if (!fifo_out_full) begin
          fifo_out_w_en = 1'b1;
          op_count_d    = op_count_q + COUNT_SIZE'(1);
          state_d       = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      id_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      out_q      <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      id_q       <= id_d;
      a_q        <= a_d;
      b_q        <= b_d;
      out_q      <= out_d;
      op_count_q <= op_count_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign fifo_out_data = out_q;
  assign op_count      = op_count_q;

endmodule

// File: tb/tb_alu_fifo_dispatcher.sv
// Scoreboard bench for alu_fifo_dispatcher: FIFO_IN model feeds commands, a monitor
// compares every FIFO_OUT push against results from a behavioural ALU model.
module tb_alu_fifo_dispatcher;

  logic        clk;
  logic        rst_n;
  logic [41:0] fifo_in_data;
  logic        fifo_in_empty;
  logic        fifo_in_r_en;
  logic        fifo_out_full;
  logic        fifo_out_w_en;
  logic [24:0] fifo_out_data;
  logic        busy;
  logic [15:0] op_count;

  logic [41:0] in_q[$];
  logic [24:0] exp_q[$];
  logic [15:0] exp_count;
  int unsigned pass_cnt;
  int unsigned total_cnt;
  bit          rand_full_en;

  alu_fifo_dispatcher #(
    .OPERATION_SIZE(2),
    .ID_SIZE       (8),
    .DATA_SIZE     (16),
    .COUNT_SIZE    (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_in_data (fifo_in_data),
    .fifo_in_empty(fifo_in_empty),
    .fifo_in_r_en (fifo_in_r_en),
    .fifo_out_full(fifo_out_full),
    .fifo_out_w_en(fifo_out_w_en),
    .fifo_out_data(fifo_out_data),
    .busy         (busy),
    .op_count     (op_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  function automatic logic [41:0] pack(input logic [1:0] op, input logic [7:0] id,
                                       input logic [15:0] a, input logic [15:0] b);
    return {b, a, id, op};
  endfunction

  // Reference ALU: plain integer arithmetic reduced to 17 bits.
  function automatic logic [24:0] model(input logic [1:0] op, input logic [7:0] id,
                                        input logic [15:0] a, input logic [15:0] b);
    int unsigned ua;
    int unsigned ub;
    int unsigned r;
    logic [16:0] r17;
    ua = a;
    ub = b;
    case (op)
      2'd0:    r = ua + ub;
      2'd1:    r = (ua - ub) & 32'h1FFFF;
      2'd2:    r = ua & ub;
      default: r = ua ^ ub;
    endcase
    r17 = r[16:0];
    return {id, r17};
  endfunction

  task automatic enq(input logic [1:0] op, input logic [7:0] id,
                     input logic [15:0] a, input logic [15:0] b);
    in_q.push_back(pack(op, id, a, b));
    exp_q.push_back(model(op, id, a, b));
    fifo_in_empty = 1'b0;
  endtask

  task automatic enq_lit(input logic [1:0] op, input logic [7:0] id,
                         input logic [15:0] a, input logic [15:0] b, input logic [24:0] e);
    in_q.push_back(pack(op, id, a, b));
    exp_q.push_back(e);
    fifo_in_empty = 1'b0;
  endtask

  task automatic wait_drain(input int unsigned budget);
    bit done;
    done = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && in_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain_done", 64'(done), 64'd1);
  endtask

  // FIFO_IN model: read data appears the cycle after the pop strobe.
  initial begin
    logic take;
    fifo_in_data = '0;
    forever begin
      @(negedge clk);
      take = fifo_in_r_en;
      @(posedge clk);
      #2;
      if (take && in_q.size() > 0) fifo_in_data = in_q.pop_front();
      fifo_in_empty = (in_q.size() == 0);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_full_en) fifo_out_full = ($urandom_range(0, 3) == 0);
    end
  end

  // Monitor: every push is popped against the scoreboard.
  initial begin
    logic [24:0] e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b0) begin
        exp_count = '0;
      end else begin
        if (fifo_out_w_en) begin
          chk("push_while_full", 64'(fifo_out_full), 64'd0);
          if (exp_q.size() == 0) begin
            chk("unexpected_push", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("push_data", 64'(fifo_out_data), 64'(e));
            chk("push_count", 64'(op_count), 64'(exp_count));
          end
          exp_count = exp_count + 16'd1;
        end
        if (fifo_in_r_en) chk("pop_nonempty", 64'(in_q.size() > 0), 64'd1);
      end
    end
  end

  initial begin
    int unsigned ir, iw, bad_r, bad_b, bad_w, bad_d;
    int unsigned rp[$];
    logic [24:0] snap;
    logic [15:0] cnt0;
    logic [1:0]  rop;
    logic [15:0] ra, rb;

    pass_cnt      = 0;
    total_cnt     = 0;
    exp_count     = '0;
    rand_full_en  = 1'b0;
    rst_n         = 1'b0;
    fifo_in_empty = 1'b1;
    fifo_out_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_r_en", 64'(fifo_in_r_en), 64'd0);
    chk("rst_w_en", 64'(fifo_out_w_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_data", 64'(fifo_out_data), 64'd0);
    chk("rst_count", 64'(op_count), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // ADD with carry and pop/push latency
    @(posedge clk);
    #1 enq_lit(2'd0, 8'h5A, 16'hFFFF, 16'h0001, 25'hB50000);
    ir = 99;
    iw = 99;
    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_in_r_en && ir == 99) ir = i;
      if (fifo_out_w_en) begin
        iw = i;
        break;
      end
    end
    chk("add_r_en_cycle", 64'(ir), 64'd1);
    chk("add_w_en_cycle", 64'(iw), 64'd4);
    @(negedge clk);
    chk("add_count", 64'(op_count), 64'd1);

    // SUB / AND / XOR directed vectors
    @(posedge clk);
    #1;
    enq_lit(2'd1, 8'h01, 16'h0003, 16'h0005, 25'h03FFFE);
    enq_lit(2'd2, 8'h10, 16'hF0F0, 16'h0FF0, 25'h2000F0);
    enq_lit(2'd3, 8'hFF, 16'hAAAA, 16'h5555, 25'h1FEFFFF);
    wait_drain(100);

    // Empty FIFO: nothing happens
    bad_r = 0;
    bad_b = 0;
    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_in_r_en) bad_r++;
      if (busy) bad_b++;
    end
    chk("empty_r_en", 64'(bad_r), 64'd0);
    chk("empty_busy", 64'(bad_b), 64'd0);

    // Three back-to-back commands
    @(posedge clk);
    #1;
    enq(2'd0, 8'h21, 16'h1234, 16'h4321);
    enq(2'd1, 8'h22, 16'h0000, 16'h0001);
    enq(2'd3, 8'h23, 16'hFFFF, 16'h0F0F);
    for (int unsigned i = 0; i < 40; i++) begin
      @(negedge clk);
      if (fifo_in_r_en) rp.push_back(i);
    end
    chk("b2b_pops", 64'(rp.size()), 64'd3);
    if (rp.size() == 3) begin
      chk("b2b_gap0", 64'(rp[1] - rp[0]), 64'd5);
      chk("b2b_gap1", 64'(rp[2] - rp[1]), 64'd5);
    end
    wait_drain(50);

    // Backpressure in PUSH with a second command queued behind
    @(posedge clk);
    #1;
    fifo_out_full = 1'b1;
    enq(2'd0, 8'h31, 16'h8000, 16'h8000);
    enq(2'd2, 8'h32, 16'h00FF, 16'hFFFF);
    repeat (4) @(posedge clk);
    @(negedge clk);
    snap = fifo_out_data;
    cnt0 = op_count;
    chk("bp_data", 64'(snap), 64'(model(2'd0, 8'h31, 16'h8000, 16'h8000)));
    bad_w = 0;
    bad_r = 0;
    bad_b = 0;
    bad_d = 0;
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_out_w_en) bad_w++;
      if (fifo_in_r_en) bad_r++;
      if (!busy) bad_b++;
      if (fifo_out_data !== snap) bad_d++;
    end
    chk("bp_w_en", 64'(bad_w), 64'd0);
    chk("bp_r_en", 64'(bad_r), 64'd0);
    chk("bp_busy", 64'(bad_b), 64'd0);
    chk("bp_stable", 64'(bad_d), 64'd0);
    @(posedge clk);
    #1 fifo_out_full = 1'b0;
    @(negedge clk);
    chk("bp_release_w_en", 64'(fifo_out_w_en), 64'd1);
    @(negedge clk);
    chk("bp_single_pulse", 64'(fifo_out_w_en), 64'd0);
    chk("bp_count", 64'(op_count), 64'(cnt0 + 16'd1));
    wait_drain(50);

    // Reset during EXEC discards the popped command
    @(posedge clk);
    #1;
    enq(2'd1, 8'h41, 16'h0010, 16'h0020);
    enq(2'd0, 8'h42, 16'h0100, 16'h0200);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    void'(exp_q.pop_front());
    #1;
    chk("rst_mid_r_en", 64'(fifo_in_r_en), 64'd0);
    chk("rst_mid_w_en", 64'(fifo_out_w_en), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_data", 64'(fifo_out_data), 64'd0);
    chk("rst_mid_count", 64'(op_count), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_drain(50);
    chk("rst_after_count", 64'(op_count), 64'd1);

    // Randomized traffic with random backpressure
    rand_full_en = 1'b1;
    for (int unsigned n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
      rb  = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
      @(posedge clk);
      #1 enq(rop, 8'($urandom), ra, rb);
      repeat ($urandom_range(0, 6)) @(posedge clk);
    end
    rand_full_en = 1'b0;
    @(posedge clk);
    #1 fifo_out_full = 1'b0;
    wait_drain(600);

    // Counter wrap from all-ones
    @(negedge clk);
    force dut.op_count_q = 16'hFFFF;
    exp_count = 16'hFFFF;
    @(posedge clk);
    #1 release dut.op_count_q;
    @(negedge clk);
    chk("wrap_preset", 64'(op_count), 64'hFFFF);
    @(posedge clk);
    #1 enq(2'd3, 8'h77, 16'h1357, 16'h2468);
    wait_drain(50);
    chk("wrap_count", 64'(op_count), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
